// File: rtl/bcd_serial_subtractor_pkg.sv
// bcd_pkg: shared BCD constants and FSM state type for the serial subtractor
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TEN_CORR = 4'd10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bcd_serial_subtractor_if.sv
// bcd_serial_subtractor_if: start/busy/done handshake plus operand and result bus
interface bcd_serial_subtractor_if import bcd_pkg::*; #(parameter int DIGITS = 4);
  logic start;
  logic [DIGIT_W*DIGITS-1:0] Minuend;
  logic [DIGIT_W*DIGITS-1:0] Subtrahend;
  logic busy;
  logic done;
  logic [DIGIT_W*DIGITS-1:0] Difference;
  logic Borrow_out;
  logic Error;
  modport master(output start, Minuend, Subtrahend, input busy, done, Difference, Borrow_out, Error);
  modport slave(input start, Minuend, Subtrahend, output busy, done, Difference, Borrow_out, Error);
endinterface

// File: rtl/bcd_serial_subtractor_digit.sv
// bcd_digit_subtractor: one BCD digit of A - B - Borrow_in with +10 correction
module bcd_digit_subtractor import bcd_pkg::*; (
  input  logic [DIGIT_W-1:0] A,
  input  logic [DIGIT_W-1:0] B,
  input  logic               Borrow_in,
  output logic [DIGIT_W-1:0] Diff,
  output logic               Borrow_out,
  output logic               Digit_invalid
);
  logic signed [DIGIT_W:0] d;
  assign d = $signed({1'b0, A}) - $signed({1'b0, B}) - $signed({{DIGIT_W{1'b0}}, Borrow_in});
  assign Borrow_out = d[DIGIT_W];
  // low nibble of d+10 equals (d mod 16)+10 mod 16, so the sign bit can be dropped
  assign Diff = Borrow_out ? d[DIGIT_W-1:0] + TEN_CORR : d[DIGIT_W-1:0];
  assign Digit_invalid = (A > BCD_MAX) || (B > BCD_MAX);
endmodule

// File: rtl/bcd_serial_subtractor.sv
// bcd_serial_subtractor: packed-BCD Minuend - Subtrahend, one digit per clock, LSD first
module bcd_serial_subtractor import bcd_pkg::*; #(parameter int DIGITS = 4) (
  input logic clk,
  input logic reset,
  bcd_serial_subtractor_if.slave bus
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  state_t state, nxt;
  logic [W-1:0] a_sr, b_sr, acc, acc_nxt, diff_q;
  logic [IW-1:0] idx;
  logic [DIGIT_W-1:0] dig;
  logic borrow, err, err_nxt, bout_q, err_q, dig_bo, dig_inv, last, accept;
  bcd_digit_subtractor u_dig (
    .A(a_sr[DIGIT_W-1:0]), .B(b_sr[DIGIT_W-1:0]), .Borrow_in(borrow),
    .Diff(dig), .Borrow_out(dig_bo), .Digit_invalid(dig_inv)
  );
  assign accept = state == IDLE && bus.start;
  assign last = idx == IW'(DIGITS - 1);
  // new digit enters at the top so digit 0 lands in bits [3:0] after DIGITS shifts
  assign acc_nxt = W'({dig, acc} >> DIGIT_W);
  assign err_nxt = err | dig_inv;
  always_comb begin
    nxt = IDLE;
    nxt = accept ? RUN : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : nxt;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      acc <= '0;
      idx <= '0;
      borrow <= 1'b0;
      err <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      err_q <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.Minuend;
      b_sr <= bus.Subtrahend;
      acc <= '0;
      idx <= '0;
      borrow <= 1'b0;
      err <= 1'b0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> DIGIT_W;
      b_sr <= b_sr >> DIGIT_W;
      acc <= acc_nxt;
      idx <= idx + IW'(1);
      borrow <= dig_bo;
      err <= err_nxt;
      if (last) begin
        diff_q <= err_nxt ? '0 : acc_nxt;
        bout_q <= err_nxt ? 1'b0 : dig_bo;
        err_q <= err_nxt;
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.Difference = diff_q;
  assign bus.Borrow_out = bout_q;
  assign bus.Error = err_q;
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb_bcd_serial_subtractor: decimal-arithmetic model plus directed vectors for the BCD subtractor
module tb_bcd_serial_subtractor;
  localparam int DIGITS = 4;
  localparam int W = 4 * DIGITS;
  typedef struct packed {logic [W-1:0] d; logic b; logic e;} res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bcd_serial_subtractor_if #(.DIGITS(DIGITS)) bus();
  bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int compared = 0;
  int mismatched = 0;
  int done_cnt = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] m, input logic [W-1:0] s);
    res_t r;
    int mi, si, df, p10;
    logic e;
    mi = 0; si = 0; p10 = 1; e = 1'b0;
    r = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      mi = mi * 10 + int'(m[4*i +: 4]);
      si = si * 10 + int'(s[4*i +: 4]);
      if (m[4*i +: 4] > 4'd9 || s[4*i +: 4] > 4'd9) e = 1'b1;
      p10 = p10 * 10;
    end
    if (e) begin
      r.e = 1'b1;
      return r;
    end
    df = mi - si;
    r.b = df < 0;
    if (df < 0) df = df + p10;
    for (int i = 0; i < DIGITS; i++) begin
      r.d[4*i +: 4] = 4'(df % 10);
      df = df / 10;
    end
    return r;
  endfunction

  // transaction-level model: phase counts edges since the accept edge
  logic act = 1'b0;
  int phase = 0;
  res_t pend = '0;
  res_t pub = '0;
  always @(posedge clk) begin
    if (reset) begin
      act <= 1'b0;
      phase <= 0;
      pub <= '0;
    end else if (!act) begin
      if (bus.start) begin
        act <= 1'b1;
        phase <= 0;
        pend <= model(bus.Minuend, bus.Subtrahend);
      end
    end else begin
      phase <= phase + 1;
      if (phase == DIGITS - 1) pub <= pend;
      if (phase == DIGITS) act <= 1'b0;
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("busy", 32'(bus.busy), 32'(act));
    chk("done", 32'(bus.done), 32'(act && phase == DIGITS));
    chk("Difference", 32'(bus.Difference), 32'(pub.d));
    chk("Borrow_out", 32'(bus.Borrow_out), 32'(pub.b));
    chk("Error", 32'(bus.Error), 32'(pub.e));
    if (bus.done) done_cnt++;
  end

  task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] s, input logic [W-1:0] ed,
                        input logic eb, input logic ee, input string nm);
    int n, nb;
    n = 0; nb = 0;
    bus.Minuend = m; bus.Subtrahend = s; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.Minuend = '1; bus.Subtrahend = '1;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      n++;
      @(negedge clk);
    end
    if (bus.busy) nb++;
    chk({nm, " latency"}, 32'(n), 32'(DIGITS));
    chk({nm, " diff"}, 32'(bus.Difference), 32'(ed));
    chk({nm, " borrow"}, 32'(bus.Borrow_out), 32'(eb));
    chk({nm, " error"}, 32'(bus.Error), 32'(ee));
    @(negedge clk);
    if (bus.busy) nb++;
    chk({nm, " busy cycles"}, 32'(nb), 32'(DIGITS + 1));
  endtask

  int d0;
  initial begin
    bus.start = 1'b0; bus.Minuend = '0; bus.Subtrahend = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_on = 1'b1;
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset diff", 32'(bus.Difference), 32'd0);
    chk("model pin 5732-1845", 32'(model(16'h5732, 16'h1845)), {15'd0, 16'h3887, 1'b0, 1'b0});
    chk("model pin 1845-5732", 32'(model(16'h1845, 16'h5732)), {15'd0, 16'h6113, 1'b1, 1'b0});
    run_op(16'h5732, 16'h1845, 16'h3887, 1'b0, 1'b0, "basic");
    run_op(16'h1845, 16'h5732, 16'h6113, 1'b1, 1'b0, "negative");
    run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, "ripple");
    run_op(16'h4242, 16'h4242, 16'h0000, 1'b0, 1'b0, "equal");
    run_op(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, "invalid");
    run_op(16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, "after invalid");
    run_op(16'h0000, 16'h9999, 16'h0001, 1'b1, 1'b0, "max borrow");
    // start pulse during RUN must be ignored
    d0 = done_cnt;
    bus.Minuend = 16'h5732; bus.Subtrahend = 16'h1845; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.Minuend = 16'h9999; bus.Subtrahend = 16'h0000; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored start dones", 32'(done_cnt - d0), 32'd1);
    chk("ignored start diff", 32'(bus.Difference), 32'h3887);
    // reset while RUN is at digit index 2
    bus.Minuend = 16'h9999; bus.Subtrahend = 16'h1111; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    d0 = done_cnt;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort diff", 32'(bus.Difference), 32'd0);
    repeat (8) @(negedge clk);
    chk("abort no done", 32'(done_cnt - d0), 32'd0);
    run_op(16'h0100, 16'h0099, 16'h0001, 1'b0, 1'b0, "post reset");
    // start held high gives back-to-back operations
    d0 = done_cnt;
    bus.Minuend = 16'h0003; bus.Subtrahend = 16'h0005; bus.start = 1'b1;
    repeat (6) @(negedge clk);
    bus.Minuend = 16'h0050; bus.Subtrahend = 16'h0020;
    repeat (8) @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("back-to-back dones", 32'(done_cnt - d0), 32'd3);
    chk("back-to-back diff", 32'(bus.Difference), 32'h0030);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
